// File: rtl/gpack.sv
// Serial-to-parallel word packer: assembles DWIDTH-bit words into NUM_WORDS-slot bus words.
// Optional GPACK_ZERO_FILL_EN clears the accumulator on every completion so unused slots read 0.
module gpack #(
  parameter int unsigned DWIDTH     = 1,
  parameter int unsigned SELWIDTH   = 2,
  parameter int unsigned BIGENDIAN  = 0,
  parameter int unsigned TOT_DWIDTH = DWIDTH << SELWIDTH,
  parameter int unsigned NUM_WORDS  = 1 << SELWIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DWIDTH-1:0]     in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [TOT_DWIDTH-1:0] out_data,
  output logic [SELWIDTH:0]     out_count,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned CW = SELWIDTH + 1;
  localparam logic [SELWIDTH-1:0] LAST_IDX = SELWIDTH'(NUM_WORDS - 1);

  logic [SELWIDTH-1:0]   idx_q, idx_d;
  logic [TOT_DWIDTH-1:0] acc_q, acc_d;
  logic [TOT_DWIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]         out_count_q, out_count_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;

  logic [SELWIDTH-1:0]   slot;
  logic [TOT_DWIDTH-1:0] merged;
  logic                  in_xfer;
  logic                  complete;

  // Ready only when the holding register is empty or draining this cycle.
  assign in_ready  = reset_n & (~out_valid_q | out_ready);
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    slot     = (BIGENDIAN != 0) ? (LAST_IDX - idx_q) : idx_q;
    in_xfer  = in_valid & in_ready;
    complete = in_xfer & ((idx_q == LAST_IDX) | in_last);

    // Current word merged into its slot of the accumulator.
    merged = acc_q;
    for (int unsigned s = 0; s < NUM_WORDS; s++) begin
      if (slot == SELWIDTH'(s)) begin
        merged[s*DWIDTH +: DWIDTH] = in_data;
      end
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (in_xfer) begin
      if (complete) begin
        out_data_d  = merged;
        out_count_d = CW'(idx_q) + CW'(1);
        out_last_d  = in_last;
        out_valid_d = 1'b1;
        idx_d       = '0;
`ifdef GPACK_ZERO_FILL_EN
        acc_d       = '0;
`else
        acc_d       = merged;
`endif
      end else begin
        acc_d = merged;
        idx_d = idx_q + SELWIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_gpack.sv
// Self-checking bench for gpack: little- and big-endian instances share one stimulus stream
// and are compared against a packet-grouping reference model.
module tb_gpack;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;

  logic        le_in_ready, be_in_ready;
  logic [31:0] le_out_data, be_out_data;
  logic [2:0]  le_out_count, be_out_count;
  logic        le_out_last, be_out_last;
  logic        le_out_valid, be_out_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: words of the packet group being collected and the expected held output.
  logic [7:0]  grp[$];
  bit          exp_valid = 1'b0;
  bit          exp_last  = 1'b0;
  int          exp_cnt   = 0;
  logic [31:0] exp_le = '0, exp_be = '0, mask_le = '0, mask_be = '0;

  always #5 clk = ~clk;

  gpack #(.DWIDTH(8), .SELWIDTH(2), .BIGENDIAN(0)) u_le (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(le_in_ready), .out_data(le_out_data), .out_count(le_out_count),
    .out_last(le_out_last), .out_valid(le_out_valid), .out_ready(out_ready));

  gpack #(.DWIDTH(8), .SELWIDTH(2), .BIGENDIAN(1)) u_be (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(be_in_ready), .out_data(be_out_data), .out_count(be_out_count),
    .out_last(be_out_last), .out_valid(be_out_valid), .out_ready(out_ready));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Close the collected group into the expected output word.
  task automatic close_group(input bit last);
    exp_le = '0; exp_be = '0; mask_le = '0; mask_be = '0;
    exp_cnt = grp.size();
    for (int k = 0; k < exp_cnt; k++) begin
      exp_le  = exp_le  | (32'(grp[k]) << (8*k));
      exp_be  = exp_be  | (32'(grp[k]) << (8*(3-k)));
      mask_le = mask_le | (32'hFF << (8*k));
      mask_be = mask_be | (32'hFF << (8*(3-k)));
    end
    exp_last  = last;
    exp_valid = 1'b1;
    grp.delete();
  endtask

  task automatic check_outputs();
    chk("valid_le", 32'(le_out_valid), 32'(exp_valid));
    chk("valid_be", 32'(be_out_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("count_le", 32'(le_out_count), 32'(exp_cnt));
      chk("count_be", 32'(be_out_count), 32'(exp_cnt));
      chk("last_le", 32'(le_out_last), 32'(exp_last));
      chk("last_be", 32'(be_out_last), 32'(exp_last));
`ifdef GPACK_ZERO_FILL_EN
      chk("data_le", le_out_data, exp_le);
      chk("data_be", be_out_data, exp_be);
`else
      chk("data_le", le_out_data & mask_le, exp_le);
      chk("data_be", be_out_data & mask_be, exp_be);
`endif
    end
  endtask

  // One clock of stimulus; called just after a rising edge.
  task automatic step(input bit iv, input logic [7:0] d, input bit il, input bit ordy);
    bit exp_rdy;
    bit completing;
    in_valid = iv; in_data = d; in_last = il; out_ready = ordy;
    #1;
    exp_rdy = !exp_valid || ordy;
    chk("in_ready_le", 32'(le_in_ready), 32'(exp_rdy));
    chk("in_ready_be", 32'(be_in_ready), 32'(exp_rdy));
    completing = 1'b0;
    if (iv && exp_rdy) begin
      grp.push_back(d);
      if (grp.size() == 4 || il) completing = 1'b1;
    end
    if (completing) close_group(il);
    else if (exp_valid && ordy) exp_valid = 1'b0;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("rst_valid", 32'(le_out_valid | be_out_valid), 32'd0);
    chk("rst_data", le_out_data | be_out_data, 32'd0);
    chk("rst_count", 32'(le_out_count | be_out_count), 32'd0);
    chk("rst_last", 32'(le_out_last | be_out_last), 32'd0);
    chk("rst_in_ready", 32'(le_in_ready | be_in_ready), 32'd0);
    grp.delete();
    exp_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Full word, both endiannesses.
    step(1, 8'h11, 0, 1); step(1, 8'h22, 0, 1); step(1, 8'h33, 0, 1); step(1, 8'h44, 0, 1);
    chk("full_le_const", le_out_data, 32'h44332211);
    chk("full_be_const", be_out_data, 32'h11223344);
    step(0, 8'h00, 0, 1);

    // Partial flush, then the next word starts at slot 0.
    step(1, 8'hAA, 0, 1); step(1, 8'hBB, 1, 1);
    chk("partial_count_const", 32'(le_out_count), 32'd2);
    step(1, 8'h5A, 1, 1);
    step(0, 8'h00, 0, 1);

    // Backpressure: 8 words offered with out_ready low, then drained.
    for (int i = 0; i < 8; i++) step(1, 8'(8'h80 + i), 0, 0);
    chk("bp_data_const", le_out_data, 32'h83828180);
    for (int i = 4; i < 8; i++) step(1, 8'(8'h80 + i), 0, 1);
    step(0, 8'h00, 0, 1);

    // Streaming at full rate.
    for (int i = 0; i < 12; i++) step(1, 8'(8'hC0 + i), 0, 1);
    step(0, 8'h00, 0, 1);

    // in_last at the final slot gives a full word with out_last set.
    step(1, 8'h01, 0, 1); step(1, 8'h02, 0, 1); step(1, 8'h03, 0, 1); step(1, 8'h04, 1, 1);
    step(0, 8'h00, 1, 1);

    // Reset mid-packet discards the partial word.
    step(1, 8'hEE, 0, 1); step(1, 8'hDD, 0, 1);
    do_reset();
    step(1, 8'h01, 0, 1); step(1, 8'h02, 0, 1); step(1, 8'h03, 0, 1); step(1, 8'h04, 0, 1);
    chk("post_reset_const", le_out_data, 32'h04030201);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 3) != 0), 8'($urandom), bit'($urandom_range(0, 5) == 0),
           bit'($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpack.md
# gpack

Serial-to-parallel word packer for the MAC datapath: accepts a stream of `DWIDTH`-bit words and assembles them into one `TOT_DWIDTH`-bit bus word of `NUM_WORDS` slots. Word 0 lands in bits `[DWIDTH-1:0]`, or in the top slot when `BIGENDIAN=1`. It is the write-side counterpart of the datapath's slot-select mux, and uses the same concatenated-bus slot layout. Packets that end early (`in_last`) are flushed as partial words, with a count of valid slots.

## Interface
Parameters:
- `DWIDTH`, 1: width of one input word.
- `SELWIDTH`, 2: log2 of slots per output word.
- `BIGENDIAN`, 0: 0 puts word k in bits `[k*DWIDTH +: DWIDTH]`; 1 puts it in slot `NUM_WORDS-1-k`.
- `TOT_DWIDTH`, `DWIDTH<<SELWIDTH`: output bus width.
- `NUM_WORDS`, `1<<SELWIDTH`: slots per output word.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_data` in `DWIDTH`: input word.
- `in_valid` in 1: `in_data`/`in_last` valid.
- `in_last` in 1: final word of packet, forces flush.
- `in_ready` out 1: packer can accept a word this cycle.
- `out_data` out `TOT_DWIDTH`: packed word.
- `out_count` out `SELWIDTH+1`: number of valid slots, 1..`NUM_WORDS`.
- `out_last` out 1: packed word ends a packet.
- `out_valid` out 1: `out_data`/`out_count`/`out_last` valid.
- `out_ready` in 1: downstream accepts the output.

## Operation
- Input transfer is `in_valid & in_ready`; output transfer is `out_valid & out_ready`.
- `in_ready` is `reset_n & (~out_valid | out_ready)` and is combinational.
- Internal state:
  - slot index `idx` (`SELWIDTH` bits);
  - accumulator register `acc` (`TOT_DWIDTH`);
  - output holding registers.
- On an input transfer that does not complete the word: write `in_data` into slot `idx` (mapped per `BIGENDIAN`) of `acc`, then `idx <= idx+1`.
- A word completes when `idx == NUM_WORDS-1` or `in_last=1`. On completion:
  - `out_data <= acc` with the current word merged into its slot;
  - `out_count <= idx+1`;
  - `out_last <= in_last`;
  - `out_valid <= 1`;
  - `idx <= 0`;
  - `acc` is cleared (see Configuration).
- `in_last` at `idx == NUM_WORDS-1` produces a full word with `out_last=1`.
- `out_valid` clears on an output transfer with no completing input in the same cycle. If both happen in the same cycle, the new word replaces the old one and `out_valid` stays 1, so back-to-back words flow at full rate.
- Output registers hold stable while `out_valid & ~out_ready`.
- `idx` wraps from `NUM_WORDS-1` to 0 with no gap cycle.

## Timing
- Latency: the completing input transfer at edge N gives `out_valid=1` after edge N.
- Throughput: one input word per cycle while `out_ready=1`.
- Backpressure: the cycle after `out_valid` rises with `out_ready=0`, `in_ready=0`. The accumulator stalls until the output drains.
- Reset values, asynchronous on `reset_n` low:
  - `out_valid=0`, `out_data=0`, `out_count=0`, `out_last=0`;
  - `idx=0`, `acc=0`;
  - `in_ready=0` while `reset_n` is low.
- Reset mid-packet discards the partial accumulation. The first transfer after release goes to slot 0.
- Input signals are ignored when `in_valid=0`. `in_last` without `in_valid` has no effect.

## Configuration
- `GPACK_ZERO_FILL_EN` defined:
  - `acc` is cleared to 0 on every completion;
  - unused slots of a partial word read as 0.
- Not defined:
  - `acc` is not cleared;
  - unused slots of a partial word carry stale data from earlier words and must be qualified by `out_count`;
  - `acc` still resets to 0.

## Test plan
All scenarios use `DWIDTH=8`, `SELWIDTH=2`.
- **Little-endian full word:** `BIGENDIAN=0`, words 0x11,0x22,0x33,0x44 on 4 consecutive cycles, `out_ready=1` -> one cycle after 0x44: `out_data=0x44332211`, `out_count=4`, `out_last=0`.
- **Big-endian full word:** `BIGENDIAN=1`, same stimulus -> `out_data=0x11223344`, `out_count=4`.
- **Partial flush:** zero-fill enabled, 0xAA then 0xBB with `in_last=1` -> `out_data=0x0000BBAA`, `out_count=2`, `out_last=1`. The next word starts at slot 0.
- **Backpressure:** `out_ready=0`, stream 8 words -> first 4 accepted, `out_valid=1`, `in_ready=0`, and `out_data` stable. Raising `out_ready` drains the word, and the remaining 4 are then accepted in order.
- **Streaming:** 12 consecutive words, `out_ready=1` -> 3 output words on cycles 4, 8, 12 after the first input, with no `in_ready` deassertion.
- **Reset mid-packet:** 2 words accepted, then `reset_n` pulsed low -> all outputs 0. Words 0x01..0x04 after release -> `out_data=0x04030201`.
